// File: rtl/stream_sink_pkg.sv
// Shared types and helpers for the EOT-terminated stream drain sink.
package stream_sink_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TOKEN_W = DATA_W + 1;
  localparam int unsigned EOT_BIT = DATA_W;
  localparam int unsigned MAX_W   = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sink_state_e;

  // Rotate-left-by-one within the low w bits, then XOR in the payload.
  function automatic logic [MAX_W-1:0] rotl1_xor(input logic [MAX_W-1:0] cs,
                                                 input logic [MAX_W-1:0] data,
                                                 input int unsigned      w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return (((cs << 1) | (cs >> (w - 1))) & mask) ^ (data & mask);
  endfunction

endpackage

// File: rtl/stream_drain_sink_if.sv
// FIFO read-side port for an EOT token stream (token = EOT flag + payload).
interface stream_drain_sink_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH:0] dout;
  logic                empty_n;
  logic                read;

  modport master (output dout, output empty_n, input read);
  modport slave  (input dout, input empty_n, output read);
endinterface

// File: rtl/stream_drain_sink.sv
// ap_ctrl_hs sink that drains an EOT stream, counting tokens and folding a checksum.
module stream_drain_sink
  import stream_sink_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 64
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [CNT_WIDTH-1:0]  n,
  stream_drain_sink_if.slave    c_s,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  underrun,
  output logic                  overrun
);

  sink_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cs_q, cs_d;
  logic                  under_q, under_d;
  logic                  over_q, over_d;
  logic [MAX_W-1:0]      fold;
  logic                  is_eot;

  assign is_eot = c_s.dout[DATA_WIDTH];
  assign fold   = rotl1_xor(MAX_W'(cs_q), MAX_W'(c_s.dout[DATA_WIDTH-1:0]), DATA_WIDTH);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    cs_d     = cs_q;
    under_d  = under_q;
    over_d   = over_q;
    c_s.read = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          n_d     = n;
          cnt_d   = '0;
          cs_d    = '0;
          under_d = 1'b0;
          over_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        c_s.read = c_s.empty_n;
        if (c_s.empty_n) begin
          if (is_eot) begin
            under_d = (cnt_q < n_q);
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            cs_d  = fold[DATA_WIDTH-1:0];
            // Sticky: survives a later counter wrap back below n_q.
            if (cnt_q == n_q) over_d = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      cs_q    <= '0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  assign ap_idle  = (state_q == S_IDLE);
  assign ap_done  = (state_q == S_DONE);
  assign ap_ready = (state_q == S_DONE);
  assign count    = cnt_q;
  assign checksum = cs_q;
  assign underrun = under_q;
  assign overrun  = over_q;

endmodule

// File: tb/tb_stream_drain_sink.sv
// Directed and randomized runs of stream_drain_sink against a queue-based reference model.
module tb_stream_drain_sink;

  logic        clk;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [63:0] n;
  logic [63:0] count;
  logic [31:0] checksum;
  logic        underrun;
  logic        overrun;

  int checks;
  int errs;

  logic [32:0] tx_q[$];

  stream_drain_sink_if #(.DATA_WIDTH(32)) c_s ();

  stream_drain_sink #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (64)
  ) dut (
    .ap_clk   (clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .ap_done  (ap_done),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .n        (n),
    .c_s      (c_s),
    .count    (count),
    .checksum (checksum),
    .underrun (underrun),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_data(input int nd);
    for (int i = 0; i < nd; i++) tx_q.push_back({1'b0, 32'($urandom())});
  endtask

  task automatic push_word(input logic [31:0] w);
    tx_q.push_back({1'b0, w});
  endtask

  task automatic push_eot();
    tx_q.push_back({1'b1, 32'($urandom())});
  endtask

  // Reference: data tokens before the first EOT give count and fold; flags by comparison.
  task automatic model(input logic [63:0] nv, output logic [63:0] e_cnt, output logic [31:0] e_cs,
                       output logic e_un, output logic e_ov, output int ntok);
    e_cnt = 0;
    e_cs  = 0;
    ntok  = 0;
    foreach (tx_q[i]) begin
      ntok++;
      if (tx_q[i][32]) break;
      e_cnt++;
      e_cs = ((e_cs << 1) | (e_cs >> 31)) ^ tx_q[i][31:0];
    end
    e_un = (e_cnt < nv);
    e_ov = (e_cnt > nv);
  endtask

  // mode: 0 = always valid, 1 = empty_n toggles, 2 = random bubbles.
  task automatic do_run(input logic [63:0] nv, input int mode, input bit cont, input bit keep,
                        input int abort_after);
    logic [63:0] e_cnt;
    logic [31:0] e_cs;
    logic        e_un, e_ov;
    int          ntok, lat, bub, pops;
    bit          rd, ev, got_eot;
    model(nv, e_cnt, e_cs, e_un, e_ov, ntok);
    if (!cont) @(negedge clk);
    ap_start = 1'b1;
    n        = nv;
    @(posedge clk);
    lat = 0; bub = 0; pops = 0; got_eot = 0;
    for (int c = 0; c < 400 && !got_eot; c++) begin
      @(negedge clk);
      lat++;
      if (c == 0) begin
        if (!keep) ap_start = 1'b0;
        chk("start_clears_count", count, 64'd0);
        chk("start_clears_checksum", 64'(checksum), 64'd0);
        chk("start_clears_flags", 64'({underrun, overrun}), 64'd0);
        chk("run_not_idle", 64'(ap_idle), 64'd0);
      end
      if (mode == 0)      ev = 1'b1;
      else if (mode == 1) ev = (c % 2) == 1;
      else                ev = 1'($urandom_range(0, 1));
      if (tx_q.size() == 0) ev = 1'b0;
      c_s.empty_n = ev;
      c_s.dout    = ev ? tx_q[0] : {1'($urandom_range(0, 1)), 32'($urandom())};
      if (!ev) bub++;
      #1;
      rd = c_s.read;
      chk("read_follows_empty_n", 64'(rd), 64'(ev));
      chk("no_done_in_run", 64'(ap_done), 64'd0);
      @(posedge clk);
      if (rd && tx_q.size() != 0) begin
        got_eot = tx_q[0][32];
        void'(tx_q.pop_front());
        pops++;
      end
      if (abort_after >= 0 && pops == abort_after) begin
        #1;
        chk("count_before_reset", count, 64'(abort_after));
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_read", 64'(c_s.read), 64'd0);
        chk("rst_done", 64'({ap_done, ap_ready}), 64'd0);
        chk("rst_count", count, 64'd0);
        chk("rst_checksum", 64'(checksum), 64'd0);
        chk("rst_flags", 64'({underrun, overrun}), 64'd0);
        @(negedge clk);
        ap_rst_n    = 1'b1;
        ap_start    = 1'b0;
        c_s.empty_n = 1'b0;
        tx_q.delete();
        return;
      end
    end
    if (!got_eot) begin
      chk("eot_timeout", 64'd0, 64'd1);
      ap_start = 1'b0;
      c_s.empty_n = 1'b0;
      return;
    end
    // DONE cycle: results valid, a waiting token must not be read.
    @(negedge clk);
    lat++;
    c_s.empty_n = 1'b1;
    c_s.dout    = 33'h0_1234_5678;
    #1;
    chk("done_pulse", 64'(ap_done), 64'd1);
    chk("ready_pulse", 64'(ap_ready), 64'd1);
    chk("done_not_idle", 64'(ap_idle), 64'd0);
    chk("no_read_in_done", 64'(c_s.read), 64'd0);
    chk("latency", 64'(lat), 64'(ntok + bub + 1));
    chk("count", count, e_cnt);
    chk("checksum", 64'(checksum), 64'(e_cs));
    chk("underrun", 64'(underrun), 64'(e_un));
    chk("overrun", 64'(overrun), 64'(e_ov));
    // Following IDLE cycle: pulse gone, results held, still no read.
    @(negedge clk);
    #1;
    chk("idle_after_done", 64'(ap_idle), 64'd1);
    chk("done_one_cycle", 64'({ap_done, ap_ready}), 64'd0);
    chk("no_read_in_idle", 64'(c_s.read), 64'd0);
    chk("count_held", count, e_cnt);
    chk("checksum_held", 64'(checksum), 64'(e_cs));
    chk("flags_held", 64'({underrun, overrun}), 64'({e_un, e_ov}));
    c_s.empty_n = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errs        = 0;
    ap_rst_n    = 1'b0;
    ap_start    = 1'b0;
    n           = '0;
    c_s.empty_n = 1'b1;
    c_s.dout    = 33'h0_DEADBEEF;
    #12;
    chk("reset_idle", 64'(ap_idle), 64'd1);
    chk("reset_done_ready", 64'({ap_done, ap_ready}), 64'd0);
    chk("reset_read", 64'(c_s.read), 64'd0);
    chk("reset_count", count, 64'd0);
    chk("reset_checksum", 64'(checksum), 64'd0);
    chk("reset_flags", 64'({underrun, overrun}), 64'd0);
    @(negedge clk);
    ap_rst_n = 1'b1;
    #1;
    chk("idle_token_not_read", 64'(c_s.read), 64'd0);
    c_s.empty_n = 1'b0;

    // Basic: known golden checksum.
    push_word(32'h3F80_0000);
    push_word(32'h4040_0000);
    push_eot();
    do_run(64'd2, 0, 1'b0, 1'b0, -1);
    chk("basic_golden_checksum", 64'(checksum), 64'h3F40_0000);

    // Empty stream.
    push_eot();
    do_run(64'd0, 0, 1'b0, 1'b0, -1);

    // Underrun and overrun.
    push_data(2); push_eot();
    do_run(64'd3, 0, 1'b0, 1'b0, -1);
    push_data(3); push_eot();
    do_run(64'd1, 0, 1'b0, 1'b0, -1);
    chk("overrun_drained", 64'(tx_q.size()), 64'd0);

    // StreamAdd pattern with toggling empty_n.
    push_word(32'h3F80_0000); push_word(32'h4040_0000); push_word(32'h40A0_0000);
    push_word(32'h40E0_0000); push_word(32'h4110_0000); push_eot();
    do_run(64'd5, 1, 1'b0, 1'b0, -1);

    // Reset after 2 of 5 tokens, then a fresh run.
    push_data(5); push_eot();
    do_run(64'd5, 0, 1'b0, 1'b0, 2);
    push_data(4); push_eot();
    do_run(64'd4, 2, 1'b0, 1'b0, -1);

    // Back-to-back with ap_start held high.
    push_data(3); push_eot();
    do_run(64'd3, 0, 1'b0, 1'b1, -1);
    push_data(2); push_eot();
    do_run(64'd5, 2, 1'b1, 1'b0, -1);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      push_data(int'($urandom_range(0, 6)));
      push_eot();
      do_run(64'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 1'b0, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/stream_drain_sink.md
# stream_drain_sink

Downstream consumer of a TAPA-style end-of-transaction (EOT) token stream, such as the `c_s` output of `StreamAdd`, read through the FIFO read side.
- Under `ap_ctrl_hs` control, drains tokens until the EOT token.
- Counts data tokens and folds their payloads into a rotate-XOR checksum.
- Compares the count with the expected length `n` and reports the results when `ap_done` pulses.

## Interface
Parameters:
- `DATA_WIDTH`, 32, payload width. A token is `DATA_WIDTH+1` bits, with bit `DATA_WIDTH` as the EOT flag.
- `CNT_WIDTH`, 64, width of `n` and of the token counter.

Ports (one clock; reset is asynchronous and active-low):
- `ap_clk` in 1: sole clock, rising edge.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `ap_start` in 1: start request, sampled in IDLE.
- `ap_done` out 1: one-cycle pulse when the results are valid.
- `ap_idle` out 1: high in IDLE.
- `ap_ready` out 1: one-cycle pulse, coincident with `ap_done`.
- `n` in CNT_WIDTH: expected data-token count, latched on start.
- `c_s_dout` in DATA_WIDTH+1: FIFO head token.
- `c_s_empty_n` in 1: head token valid.
- `c_s_read` out 1: consume the head token this cycle.
- `count` out CNT_WIDTH: data tokens consumed, excluding EOT.
- `checksum` out DATA_WIDTH: rotate-XOR fold of the payloads.
- `underrun` out 1: EOT arrived with `count < n`.
- `overrun` out 1: more than `n` data tokens were seen.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `ap_idle=1`.
  - On `ap_start=1`: latch `n` into `n_q`, clear the counter, checksum and flags, then go to RUN.
- **RUN:**
  - `c_s_read = c_s_empty_n`, combinational, with no full or back-pressure dependence.
  - A token is consumed on any edge where `c_s_read=1`.
  - Data token (`c_s_dout[DATA_WIDTH]=0`):
    - `cnt <= cnt+1`, wrapping modulo 2^CNT_WIDTH.
    - `cs <= rotl1(cs) ^ c_s_dout[DATA_WIDTH-1:0]`.
    - If `cnt == n_q` before the increment, set the sticky `overrun` flag.
  - EOT token: payload ignored; `underrun <= (cnt < n_q)`; go to DONE.
- **DONE:**
  - `ap_done=1`, `ap_ready=1` for exactly one cycle, then IDLE.
  - `c_s_read=0`.
- **Result outputs:** `count`, `checksum`, `underrun` and `overrun` are registers. They stay stable from DONE until the next accepted start, which clears them.
- **Overrun:** consumption continues until EOT. The block never stops draining early.
- **`ap_start` held high across DONE:** the next run is accepted in the following IDLE cycle. This gives at least one IDLE cycle between runs.
- **Tokens outside RUN:** tokens present in IDLE or DONE are not read.

## Timing
- **Reset values:**
  - state=IDLE.
  - `ap_idle=1`.
  - `ap_done=0`, `ap_ready=0`, `c_s_read=0`.
  - `count=0`, `checksum=0`, `underrun=0`, `overrun=0`.
- **Throughput:** 1 token/cycle when `c_s_empty_n` stays high.
- **Latency:** `ap_done` is asserted the cycle after the EOT read edge. Total cycles from the start edge to `ap_done` = (tokens consumed including EOT) + 1 + (cycles with `empty_n=0`).
- **Reset mid-run:** asynchronous assertion returns the block to IDLE immediately. `c_s_read` drops in the same cycle. No partial results are retained.
- **Empty bubbles:** `c_s_empty_n=0` in RUN holds all state. There is no timeout.
- **Counter wrap-around:** permitted. `overrun` keeps the sticky value it already has.

## Structure
- **Package `stream_sink_pkg`:**
  - `TOKEN_W`, `EOT_BIT`.
  - State enum `sink_state_e {S_IDLE, S_RUN, S_DONE}`.
  - Function `rotl1_xor(cs, data)`.
- **Module layout:** a single module with no sub-modules. An optional input skid buffer is out of scope.

## Test plan
- **Basic:** `n=2`, tokens `0x3F800000`, `0x40400000`, then EOT.
  - Expect `count=2`, `checksum=0x3F400000`, flags 0.
  - Expect `ap_done` on the cycle after the EOT read.
- **Empty stream:** `n=0`, EOT only.
  - Expect `count=0`, `checksum=0`, flags 0.
  - Expect `ap_done` 2 cycles after start.
- **Length mismatch:**
  - `n=3` with 2 data tokens + EOT: expect `underrun=1`, `overrun=0`.
  - `n=1` with 3 data tokens + EOT: expect `overrun=1`, `count=3`, and all tokens drained.
- **Bubbles:** StreamAdd pattern 1.0, 3.0, 5.0, 7.0, 9.0 plus EOT, with `empty_n` toggling every other cycle.
  - Expect `c_s_read` high only when `empty_n` is high.
  - Expect `count=5`.
  - Expect `checksum` equal to the golden model.
- **Reset mid-run:** drop `ap_rst_n` after 2 of 5 tokens.
  - Expect outputs at their reset values immediately and `ap_idle=1`.
  - A fresh run then completes correctly.
- **Back-to-back:** hold `ap_start=1` across two runs.
  - Expect one IDLE cycle between them.
  - Expect run-1 results held until the second start, then cleared.
